// File: rtl/cr_iu_lockup_rst_ctrl.sv
// Lockup recovery controller: counts down while the core stays locked up and, on expiry,
// raises a committed system reset request to sysio, reporting progress to cp0.
module cr_iu_lockup_rst_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 misc_clk,
  input  logic                 cpurst_b,
  input  logic                 iu_sysio_lockup_on,
  input  logic                 cp0_iu_lkrst_en,
  input  logic [CNT_WIDTH-1:0] cp0_iu_lkrst_timeout,
  input  logic                 retire_lockup_dbg_on,
  input  logic                 sysio_iu_lkrst_ack,
  output logic                 iu_sysio_lkrst_req,
  output logic [CNT_WIDTH-1:0] iu_cp0_lkrst_cnt,
  output logic                 iu_cp0_lkrst_busy,
  output logic                 iu_cp0_lkrst_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 req_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 arm;

  assign arm = cp0_iu_lkrst_en & iu_sysio_lockup_on & ~retire_lockup_dbg_on;

  // Handshake: req is held high from REQ entry until ack is sampled high in REQ;
  // req drops on that same edge and ack seen in any other state is ignored.
  always_ff @(posedge misc_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= CNT;
            cnt_q   <= cp0_iu_lkrst_timeout;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        CNT: begin
          // Cancel wins over expiry so a debugger can always stop the reset.
          if (!arm) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= REQ;
            busy_q  <= 1'b0;
            req_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        REQ: begin
          if (sysio_iu_lkrst_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (!iu_sysio_lockup_on) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign iu_sysio_lkrst_req = req_q;
  assign iu_cp0_lkrst_cnt   = cnt_q;
  assign iu_cp0_lkrst_busy  = busy_q;
  assign iu_cp0_lkrst_done  = done_q;

endmodule

// File: tb/tb_cr_iu_lockup_rst_ctrl.sv
// Bench for cr_iu_lockup_rst_ctrl: directed scenarios, a cycle model checked every
// negedge, and literal expectations at the key points of each scenario.
module tb_cr_iu_lockup_rst_ctrl;

  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          lock;
  logic          en;
  logic [CW-1:0] tmo;
  logic          dbg;
  logic          ack;
  logic          req;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];

  cr_iu_lockup_rst_ctrl #(.CNT_WIDTH(CW)) dut (
    .misc_clk             (clk),
    .cpurst_b             (rst_n),
    .iu_sysio_lockup_on   (lock),
    .cp0_iu_lkrst_en      (en),
    .cp0_iu_lkrst_timeout (tmo),
    .retire_lockup_dbg_on (dbg),
    .sysio_iu_lkrst_ack   (ack),
    .iu_sysio_lkrst_req   (req),
    .iu_cp0_lkrst_cnt     (cnt),
    .iu_cp0_lkrst_busy    (busy),
    .iu_cp0_lkrst_done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "watchdog");
  end

  // Model: the request is pending "remaining" more edges after the load value is captured;
  // once requested it waits for ack, then lingers until lockup clears.
  bit          m_counting, m_req, m_done, m_linger;
  int          m_remaining;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_counting = 0; m_req = 0; m_done = 0; m_linger = 0; m_remaining = 0;
    end else begin
      bit armed;
      armed = en && lock && !dbg;
      if (m_req) begin
        if (ack) begin m_req = 0; m_done = 1; m_linger = 1; end
      end else if (m_linger) begin
        if (!lock) m_linger = 0;
      end else if (m_counting) begin
        if (!armed) begin m_counting = 0; m_remaining = 0; end
        else if (m_remaining == 0) begin m_counting = 0; m_req = 1; end
        else m_remaining = m_remaining - 1;
      end else if (armed) begin
        m_counting = 1; m_remaining = int'(tmo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("model_req",  32'(req),  32'(m_req));
    check("model_busy", 32'(busy), 32'(m_counting));
    check("model_done", 32'(done), 32'(m_done));
    check("model_cnt",  32'(cnt),  32'(m_remaining));
  end

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic d, input logic a, input logic [CW-1:0] t);
    lock = l; en = e; dbg = d; ack = a; tmo = t;
  endtask

  task automatic check_cnt_seq(input string name);
    while (exp_q.size() > 0) begin
      logic [CW-1:0] e;
      tick();
      e = exp_q.pop_front();
      check(name, 32'(cnt), 32'(e));
      check({name, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    #12;
    check("rst_req", 32'(req), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    tick(2);

    // Timeout 5, ack tied low: cnt 5..0 then req at the 7th edge after arm.
    drive(1, 1, 0, 0, 16'd5);
    for (int k = 5; k >= 0; k--) exp_q.push_back(CW'(k));
    check_cnt_seq("t5_cnt");
    tick();
    check("t5_req_rise", 32'(req), 1);
    check("t5_busy_off", 32'(busy), 0);
    tick(2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_req_fall", 32'(req), 0);
    check("t5_done", 32'(done), 1);
    tick(2);
    lock = 1'b0;
    tick(2);
    check("t5_done_sticky", 32'(done), 1);

    // Cancel at cnt=4 by lockup drop, dbg rise, or enable drop; then reload to 10.
    for (int kind = 0; kind < 3; kind++) begin
      drive(1, 1, 0, 0, 16'd10);
      tick(7);
      check("cancel_at4", 32'(cnt), 4);
      if (kind == 0) lock = 1'b0;
      else if (kind == 1) dbg = 1'b1;
      else en = 1'b0;
      tick();
      check("cancel_busy", 32'(busy), 0);
      check("cancel_cnt", 32'(cnt), 0);
      check("cancel_req", 32'(req), 0);
      drive(1, 1, 0, 0, 16'd10);
      tick();
      check("reload_cnt", 32'(cnt), 10);
      drive(0, 1, 0, 0, 16'd10);
      tick(2);
    end

    // Timeout 0 with ack already high: ignored until REQ, then done in one cycle.
    drive(1, 1, 0, 1, 16'd0);
    tick();
    check("t0_busy", 32'(busy), 1);
    check("t0_req_early", 32'(req), 0);
    tick();
    check("t0_req", 32'(req), 1);
    tick();
    check("t0_req_fall", 32'(req), 0);
    drive(0, 1, 0, 0, 16'd0);
    tick(2);

    // Request is committed; async reset mid-REQ clears everything at once.
    drive(1, 1, 0, 0, 16'd3);
    tick(5);
    check("commit_req", 32'(req), 1);
    lock = 1'b0; en = 1'b0;
    tick(3);
    check("commit_hold", 32'(req), 1);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(req), 0);
    check("arst_done", 32'(done), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_cnt", 32'(cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Timeout change during countdown does not disturb the running count.
    drive(1, 1, 0, 0, 16'd8);
    for (int k = 8; k >= 6; k--) exp_q.push_back(CW'(k));
    check_cnt_seq("chg_cnt_a");
    tmo = 16'd2;
    for (int k = 5; k >= 0; k--) exp_q.push_back(CW'(k));
    check_cnt_seq("chg_cnt_b");
    tick();
    check("chg_req", 32'(req), 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
